// File: rtl/psg_mix_pkg.sv
// Shared types and constants for the PSG stereo mixer.
// Holds the FSM state encoding, the pan codes and the classic 3-channel stereo layouts.
package psg_mix_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } mix_state_t;

    localparam logic [1:0] PAN_OFF = 2'b00;
    localparam logic [1:0] PAN_L   = 2'b01;
    localparam logic [1:0] PAN_R   = 2'b10;
    localparam logic [1:0] PAN_LR  = 2'b11;

    // Channel A occupies the low pan bits: ABC = A left, B centre, C right.
    localparam logic [5:0] PAN_ABC = {PAN_R, PAN_LR, PAN_L};
    localparam logic [5:0] PAN_ACB = {PAN_LR, PAN_R, PAN_L};

endpackage

// File: rtl/psg_sat_shift.sv
// Left shift followed by unsigned saturation to OW bits; purely combinational.
module psg_sat_shift #(
    parameter int IW    = 14,
    parameter int SHIFT = 1,
    parameter int OW    = 16
) (
    input  logic [IW-1:0] i_x,
    output logic [OW-1:0] o_y
);

    localparam int SW = IW + SHIFT;

    logic [SW-1:0] w_shifted;

    assign w_shifted = SW'(i_x) << SHIFT;

    generate
        if (SW > OW) begin : g_sat
            assign o_y = (|w_shifted[SW-1:OW]) ? {OW{1'b1}} : w_shifted[OW-1:0];
        end else begin : g_pass
            assign o_y = OW'(w_shifted);
        end
    endgenerate

endmodule

// File: rtl/psg_stereo_mixer.sv
// N-channel PSG stereo mixer: accumulates one channel per clock, then shifts, saturates and holds.
// state | meaning: IDLE wait for strobe | ACC add channel idx to L/R | OUT register result, pulse out_valid
module psg_stereo_mixer
    import psg_mix_pkg::*;
#(
    parameter int CH    = 3,
    parameter int DW    = 12,
    parameter int OW    = 16,
    parameter int SHIFT = 1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              sample_stb,
    input  logic [CH*DW-1:0]  ch_in,
    input  logic [2*CH-1:0]   pan,
    input  logic              mono,
    output logic [OW-1:0]     audio_l,
    output logic [OW-1:0]     audio_r,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int AW = DW + $clog2(CH + 1);
    localparam int XW = (CH > 1) ? $clog2(CH) : 1;

    mix_state_t r_state, w_state_nxt;

    logic [CH*DW-1:0] r_ch;
    logic [2*CH-1:0]  r_pan;
    logic             r_mono;
    logic [XW-1:0]    r_idx;
    logic [AW-1:0]    r_acc_l, r_acc_r;
    logic [OW-1:0]    r_audio_l, r_audio_r;
    logic             r_out_valid, r_overrun;

    logic [DW-1:0]    w_sample;
    logic [1:0]       w_pan_sel, w_pan_eff;
    logic             w_last;
    logic [OW-1:0]    w_sat_l, w_sat_r;

    always_comb begin
        w_sample  = '0;
        w_pan_sel = PAN_OFF;
        for (int i = 0; i < CH; i++) begin
            if (r_idx == XW'(i)) begin
                w_sample  = r_ch[i*DW +: DW];
                w_pan_sel = r_pan[2*i +: 2];
            end
        end
    end

    assign w_pan_eff = r_mono ? PAN_LR : w_pan_sel;
    assign w_last    = (r_idx == XW'(CH - 1));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (sample_stb) w_state_nxt = ACC;
            ACC:     if (w_last)     w_state_nxt = OUT;
            OUT:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_ch        <= '0;
            r_pan       <= '0;
            r_mono      <= 1'b0;
            r_idx       <= '0;
            r_acc_l     <= '0;
            r_acc_r     <= '0;
            r_audio_l   <= '0;
            r_audio_r   <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            // Any strobe outside IDLE, including during OUT, is dropped.
            r_overrun   <= sample_stb && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (sample_stb) begin
                        r_ch    <= ch_in;
                        r_pan   <= pan;
                        r_mono  <= mono;
                        r_acc_l <= '0;
                        r_acc_r <= '0;
                        r_idx   <= '0;
                    end
                end
                ACC: begin
                    if (w_pan_eff[0]) r_acc_l <= r_acc_l + AW'(w_sample);
                    if (w_pan_eff[1]) r_acc_r <= r_acc_r + AW'(w_sample);
                    if (!w_last)      r_idx   <= r_idx + XW'(1);
                end
                OUT: begin
                    r_audio_l   <= w_sat_l;
                    r_audio_r   <= w_sat_r;
                    r_out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    psg_sat_shift #(.IW(AW), .SHIFT(SHIFT), .OW(OW)) u_sat_l (
        .i_x (r_acc_l),
        .o_y (w_sat_l)
    );

    psg_sat_shift #(.IW(AW), .SHIFT(SHIFT), .OW(OW)) u_sat_r (
        .i_x (r_acc_r),
        .o_y (w_sat_r)
    );

    assign audio_l   = r_audio_l;
    assign audio_r   = r_audio_r;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != IDLE);
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_psg_stereo_mixer.sv
// Directed bench for psg_stereo_mixer: default build, a SHIFT=3 saturating build and a CH=8 build.
module tb_psg_stereo_mixer;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_bad = 0;

    logic        stb0 = 0, mono0 = 0;
    logic [35:0] ch0 = '0;
    logic [5:0]  pan0 = '0;
    logic [15:0] al0, ar0;
    logic        ov0, bz0, or0;

    logic        stb1 = 0, mono1 = 0;
    logic [35:0] ch1 = '0;
    logic [5:0]  pan1 = '0;
    logic [15:0] al1, ar1;
    logic        ov1, bz1, or1;

    logic        stb2 = 0, mono2 = 0;
    logic [63:0] ch2 = '0;
    logic [15:0] pan2 = '0;
    logic [15:0] al2, ar2;
    logic        ov2, bz2, or2;

    psg_stereo_mixer #(.CH(3), .DW(12), .OW(16), .SHIFT(1)) dut0 (
        .clk_sys(clk_sys), .reset_n(reset_n), .sample_stb(stb0), .ch_in(ch0), .pan(pan0),
        .mono(mono0), .audio_l(al0), .audio_r(ar0), .out_valid(ov0), .busy(bz0), .overrun(or0));

    psg_stereo_mixer #(.CH(3), .DW(12), .OW(16), .SHIFT(3)) dut1 (
        .clk_sys(clk_sys), .reset_n(reset_n), .sample_stb(stb1), .ch_in(ch1), .pan(pan1),
        .mono(mono1), .audio_l(al1), .audio_r(ar1), .out_valid(ov1), .busy(bz1), .overrun(or1));

    psg_stereo_mixer #(.CH(8), .DW(8), .OW(16), .SHIFT(0)) dut2 (
        .clk_sys(clk_sys), .reset_n(reset_n), .sample_stb(stb2), .ch_in(ch2), .pan(pan2),
        .mono(mono2), .audio_l(al2), .audio_r(ar2), .out_valid(ov2), .busy(bz2), .overrun(or2));

    int          cur = 0;
    logic [15:0] m_l, m_r;
    logic        m_ov, m_bz, m_or;

    always_comb begin
        m_l = al0; m_r = ar0; m_ov = ov0; m_bz = bz0; m_or = or0;
        if (cur == 1) begin
            m_l = al1; m_r = ar1; m_ov = ov1; m_bz = bz1; m_or = or1;
        end else if (cur == 2) begin
            m_l = al2; m_r = ar2; m_ov = ov2; m_bz = bz2; m_or = or2;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Strobe one set into DUT sel, wait for out_valid, check latency and results.
    task automatic mix(input int sel, input logic [63:0] ch, input logic [15:0] pn,
                       input logic mn, input int el, input int er, input string tag);
        int n;
        cur = sel;
        case (sel)
            0: begin ch0 = ch[35:0]; pan0 = pn[5:0]; mono0 = mn; stb0 = 1; end
            1: begin ch1 = ch[35:0]; pan1 = pn[5:0]; mono1 = mn; stb1 = 1; end
            default: begin ch2 = ch; pan2 = pn; mono2 = mn; stb2 = 1; end
        endcase
        tick();
        stb0 = 0; stb1 = 0; stb2 = 0;
        ch0 = ~ch0; pan0 = ~pan0; mono0 = ~mono0;
        ch1 = ~ch1; pan1 = ~pan1; mono1 = ~mono1;
        ch2 = ~ch2; pan2 = ~pan2; mono2 = ~mono2;
        chk({tag, "_busy"}, 32'(m_bz), 1);
        chk({tag, "_no_orun"}, 32'(m_or), 0);
        n = 0;
        while (!m_ov && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, (sel == 2) ? 9 : 4);
        chk({tag, "_l"}, 32'(m_l), el);
        chk({tag, "_r"}, 32'(m_r), er);
        chk({tag, "_busy_fall"}, 32'(m_bz), 0);
        tick();
        chk({tag, "_ov_pulse"}, 32'(m_ov), 0);
        chk({tag, "_hold_l"}, 32'(m_l), el);
    endtask

    initial begin
        bit seen;
        repeat (3) tick();
        chk("rst_l0", 32'(al0), 0);
        chk("rst_r0", 32'(ar0), 0);
        chk("rst_ov0", 32'(ov0), 0);
        chk("rst_busy0", 32'(bz0), 0);
        chk("rst_orun0", 32'(or0), 0);
        chk("rst_l2", 32'(al2), 0);
        reset_n = 1;
        tick();

        mix(0, {12'd300, 12'd200, 12'd100}, 6'b10_11_01, 0, 600, 1000, "abc");
        mix(0, {12'd3, 12'd2, 12'd1}, 6'b00_00_00, 1, 12, 12, "mono");
        mix(0, {12'd3, 12'd2, 12'd1}, 6'b00_00_00, 0, 0, 0, "pan_off");
        mix(1, {12'd4095, 12'd4095, 12'd4095}, 6'b11_11_11, 0, 65535, 65535, "sat");
        mix(1, {12'd1000, 12'd1000, 12'd1000}, 6'b11_11_11, 0, 24000, 24000, "sh3");
        mix(2, {8{8'd255}}, {8{2'b01}}, 0, 2040, 0, "ch8");

        // Second strobe two cycles later is dropped and flagged.
        cur = 0;
        ch0 = {12'd300, 12'd200, 12'd100}; pan0 = 6'b10_11_01; mono0 = 0; stb0 = 1;
        tick();
        stb0 = 0;
        tick();
        ch0 = {3{12'd4095}}; pan0 = 6'b11_11_11; mono0 = 1; stb0 = 1;
        tick();
        stb0 = 0;
        chk("orun_pulse", 32'(or0), 1);
        chk("orun_busy", 32'(bz0), 1);
        tick();
        chk("orun_once", 32'(or0), 0);
        tick();
        chk("orun_ov", 32'(ov0), 1);
        chk("orun_l", 32'(al0), 600);
        chk("orun_r", 32'(ar0), 1000);
        mix(0, {12'd3, 12'd2, 12'd1}, 6'b00_00_00, 1, 12, 12, "back2back");

        // Strobe coinciding with OUT counts as busy.
        ch0 = {12'd300, 12'd200, 12'd100}; pan0 = 6'b10_11_01; mono0 = 0; stb0 = 1;
        tick();
        stb0 = 0;
        repeat (3) tick();
        stb0 = 1;
        tick();
        stb0 = 0;
        chk("out_stb_ov", 32'(ov0), 1);
        chk("out_stb_orun", 32'(or0), 1);
        chk("out_stb_idle", 32'(bz0), 0);
        tick();
        chk("out_stb_dropped", 32'(bz0), 0);

        // Reset in the middle of accumulation abandons the mix.
        mix(0, {12'd0, 12'd0, 12'd250}, 6'b00_00_01, 0, 500, 0, "prior");
        ch0 = {12'd300, 12'd200, 12'd100}; pan0 = 6'b10_11_01; mono0 = 0; stb0 = 1;
        tick();
        stb0 = 0;
        tick();
        reset_n = 0;
        #1;
        chk("mid_rst_l", 32'(al0), 0);
        chk("mid_rst_busy", 32'(bz0), 0);
        tick();
        reset_n = 1;
        seen = 0;
        repeat (6) begin
            tick();
            if (ov0) seen = 1;
        end
        chk("mid_rst_no_ov", 32'(seen), 0);
        chk("mid_rst_hold_l", 32'(al0), 0);
        chk("mid_rst_hold_r", 32'(ar0), 0);
        chk("mid_rst_idle", 32'(bz0), 0);
        mix(0, {12'd300, 12'd200, 12'd100}, 6'b10_11_01, 0, 600, 1000, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
